// File: rtl/immediate_encoder.sv
// Packs a sign-extended 64-bit immediate into RV64I I/S/B/J/U bit positions through a 2-stage valid/ready pipeline.
// Optional round-trip self-check enabled by defining IMM_ENC_ROUNDTRIP_CHECK_EN (adds port rt_mismatch).
module immediate_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_src,
  input  logic [63:0]          immediate,
  input  logic [31:0]          base_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instruction,
  output logic                 range_err,
  output logic                 align_err,
  input  logic                 clr_err_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
  ,
  output logic                 rt_mismatch
`endif
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [2:0] {
    SRC_I = 3'b000,
    SRC_S = 3'b001,
    SRC_B = 3'b010,
    SRC_J = 3'b011,
    SRC_U = 3'b100
  } imm_src_e;

  logic            s1_valid;
  imm_src_e        s1_src;
  logic [XLEN-1:0] s1_imm;
  logic [ILEN-1:0] s1_base;
  logic            s1_range_err;
  logic            s1_align_err;

  logic            s2_adv;
  logic            chk_range_err;
  logic            chk_align_err;
  logic [ILEN-1:0] pack_word;
  logic            err_event;

  // Stage 2 frees up when empty or draining; stage 1 follows it.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Representability and alignment of the incoming immediate.
  always_comb begin
    chk_range_err = 1'b0;
    chk_align_err = 1'b0;
    case (imm_src_e'(imm_src))
      SRC_I, SRC_S: chk_range_err = !((&immediate[63:11]) || !(|immediate[63:11]));
      SRC_B: begin
        chk_range_err = !((&immediate[63:12]) || !(|immediate[63:12]));
        chk_align_err = immediate[0];
      end
      SRC_J: begin
        chk_range_err = !((&immediate[63:20]) || !(|immediate[63:20]));
        chk_align_err = immediate[0];
      end
      SRC_U: chk_range_err = (|immediate[11:0]) ||
                             !((&immediate[63:31]) || !(|immediate[63:31]));
      default: chk_range_err = 1'b1;
    endcase
  end

  // Stage 1: capture request and check flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_src       <= SRC_I;
      s1_imm       <= '0;
      s1_base      <= '0;
      s1_range_err <= 1'b0;
      s1_align_err <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_src       <= imm_src_e'(imm_src);
        s1_imm       <= immediate;
        s1_base      <= base_instr;
        s1_range_err <= chk_range_err;
        s1_align_err <= chk_align_err;
      end
    end
  end

  // Pack immediate over base; errored requests pass base through untouched.
  always_comb begin
    pack_word = s1_base;
    if (!(s1_range_err || s1_align_err)) begin
      case (s1_src)
        SRC_I: pack_word[31:20] = s1_imm[11:0];
        SRC_S: begin
          pack_word[31:25] = s1_imm[11:5];
          pack_word[11:7]  = s1_imm[4:0];
        end
        SRC_B: begin
          pack_word[31]    = s1_imm[12];
          pack_word[7]     = s1_imm[11];
          pack_word[30:25] = s1_imm[10:5];
          pack_word[11:8]  = s1_imm[4:1];
        end
        SRC_J: begin
          pack_word[31]    = s1_imm[20];
          pack_word[19:12] = s1_imm[19:12];
          pack_word[20]    = s1_imm[11];
          pack_word[30:21] = s1_imm[10:1];
        end
        SRC_U: pack_word[31:12] = s1_imm[31:12];
        default: pack_word = s1_base;
      endcase
    end
  end

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
  logic [XLEN-1:0] rt_decoded;
  logic            rt_legal;
  logic            rt_mismatch_c;

  // Re-decode the packed word exactly as the core's decoder would.
  always_comb begin
    rt_decoded = '0;
    rt_legal   = 1'b1;
    case (s1_src)
      SRC_I: rt_decoded = {{52{pack_word[31]}}, pack_word[31:20]};
      SRC_S: rt_decoded = {{52{pack_word[31]}}, pack_word[31:25], pack_word[11:7]};
      SRC_B: rt_decoded = {{51{pack_word[31]}}, pack_word[31], pack_word[7],
                           pack_word[30:25], pack_word[11:8], 1'b0};
      SRC_J: rt_decoded = {{43{pack_word[31]}}, pack_word[31], pack_word[19:12],
                           pack_word[20], pack_word[30:21], 1'b0};
      SRC_U: rt_decoded = {{32{pack_word[31]}}, pack_word[31:12], 12'h000};
      default: rt_legal = 1'b0;
    endcase
    rt_mismatch_c = rt_legal && !s1_range_err && !s1_align_err && (rt_decoded != s1_imm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_mismatch <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      rt_mismatch <= rt_mismatch_c;
    end
  end

  assign err_event = range_err || align_err || rt_mismatch;
`else
  assign err_event = range_err || align_err;
`endif

  // Stage 2: hold packed result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      instruction <= '0;
      range_err   <= 1'b0;
      align_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        instruction <= pack_word;
        range_err   <= s1_range_err;
        align_err   <= s1_align_err;
      end
    end
  end

  // Saturating count of errored transfers; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err_cnt) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && err_event && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed self-checking bench for immediate_encoder; a second instance with ERR_CNT_W=2 covers counter saturation.
`timescale 1ns/1ps
module tb_immediate_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [63:0] immediate;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic        range_err;
  logic        align_err;
  logic        clr_err_cnt;
  logic [15:0] err_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] instruction2;
  logic        range_err2;
  logic        align_err2;
  logic [1:0]  err_cnt2;

  int checks;
  int errors;
  int exp_cnt;

  immediate_encoder #(.ERR_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_src(imm_src), .immediate(immediate), .base_instr(base_instr),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .range_err(range_err), .align_err(align_err), .clr_err_cnt(clr_err_cnt),
    .err_cnt(err_cnt)
  );

  immediate_encoder #(.ERR_CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .imm_src(imm_src), .immediate(immediate), .base_instr(base_instr),
    .out_valid(out_valid2), .out_ready(out_ready), .instruction(instruction2),
    .range_err(range_err2), .align_err(align_err2), .clr_err_cnt(clr_err_cnt),
    .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cnt();
    check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
    check("err_cnt_w2", 64'(err_cnt2), 64'((exp_cnt > 3) ? 3 : exp_cnt));
  endtask

  // One request with out_ready high; checks latency, result and error count.
  task automatic xact(input string tag, input logic [2:0] src, input logic [63:0] imm,
                      input logic [31:0] base, input logic [31:0] exp_ins,
                      input logic exp_r, input logic exp_a, input logic clr);
    int lat;
    int w;
    @(negedge clk);
    imm_src = src; immediate = imm; base_instr = base; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check({tag, "_accept_timeout"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd2);
    check({tag, "_instr"}, 64'(instruction), 64'(exp_ins));
    check({tag, "_range_err"}, 64'(range_err), 64'(exp_r));
    check({tag, "_align_err"}, 64'(align_err), 64'(exp_a));
    clr_err_cnt = clr;
    if (clr) exp_cnt = 0;
    else if (exp_r || exp_a) exp_cnt++;
    @(negedge clk);
    clr_err_cnt = 1'b0;
    check_cnt();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err_cnt = 1'b1;
    @(negedge clk);
    clr_err_cnt = 1'b0;
    exp_cnt = 0;
    check_cnt();
  endtask

  logic [2:0]  bp_src  [3];
  logic [63:0] bp_imm  [3];
  logic [31:0] bp_base [3];
  logic [31:0] bp_exp  [3];

  initial begin
    int idx;
    int k;
    int cyc;
    logic acc;
    checks = 0; errors = 0; exp_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; imm_src = '0; immediate = '0; base_instr = '0;
    out_ready = 1'b1; clr_err_cnt = 1'b0;

    bp_src[0] = 3'b000; bp_imm[0] = 64'd5;                  bp_base[0] = 32'h0000_0013; bp_exp[0] = 32'h0050_0013;
    bp_src[1] = 3'b001; bp_imm[1] = 64'd8;                  bp_base[1] = 32'h0000_0023; bp_exp[1] = 32'h0000_0423;
    bp_src[2] = 3'b100; bp_imm[2] = 64'h0000_0000_7FFF_F000; bp_base[2] = 32'h0000_0037; bp_exp[2] = 32'h7FFF_F037;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(instruction), 64'd0);
    check("rst_range_err", 64'(range_err), 64'd0);
    check("rst_align_err", 64'(align_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Legal encodings
    xact("i_neg1",  3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0, 1'b0, 1'b0);
    xact("b_800",   3'b010, 64'h0000_0000_0000_0800, 32'h0000_0063, 32'h0000_00E3, 1'b0, 1'b0, 1'b0);
    xact("u_ok",    3'b100, 64'h0000_0000_1234_5000, 32'h0000_00B7, 32'h1234_50B7, 1'b0, 1'b0, 1'b0);
    xact("u_low",   3'b100, 64'h0000_0000_1234_5001, 32'h0000_00B7, 32'h0000_00B7, 1'b1, 1'b0, 1'b0);
    xact("s_neg5",  3'b001, 64'hFFFF_FFFF_FFFF_FFFB, 32'h0000_2023, 32'hFE00_2DA3, 1'b0, 1'b0, 1'b0);
    xact("i_basei", 3'b000, 64'h0,                   32'hFFF0_0013, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    xact("j_800",   3'b011, 64'h0000_0000_0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0, 1'b0, 1'b0);
    xact("j_min",   3'b011, 64'hFFFF_FFFF_FFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0, 1'b0, 1'b0);
    xact("u_min",   3'b100, 64'hFFFF_FFFF_8000_0000, 32'h0000_0037, 32'h8000_0037, 1'b0, 1'b0, 1'b0);
    pulse_clr();

    // Error cases; counter reaches 3 then clears
    xact("i_800",   3'b000, 64'h0000_0000_0000_0800, 32'h0000_0013, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
    xact("j_odd",   3'b011, 64'h1,                   32'h0000_006F, 32'h0000_006F, 1'b0, 1'b1, 1'b0);
    xact("illegal", 3'b111, 64'h0,                   32'h0000_0013, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
    xact("j_over",  3'b011, 64'h0000_0000_0010_0000, 32'h0000_006F, 32'h0000_006F, 1'b1, 1'b0, 1'b1);
    xact("b_odd",   3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0063, 32'h0000_0063, 1'b0, 1'b1, 1'b0);
    xact("b_over",  3'b010, 64'h0000_0000_0000_1001, 32'h0000_0063, 32'h0000_0063, 1'b1, 1'b1, 1'b0);
    pulse_clr();

    // Backpressure: 4 stalled cycles with 3 pending requests
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      imm_src = bp_src[idx]; immediate = bp_imm[idx]; base_instr = bp_base[idx];
      if (out_valid) check("bp_held", 64'(instruction), 64'(bp_exp[0]));
      acc = in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_held_last", 64'(instruction), 64'(bp_exp[0]));
    out_ready = 1'b1;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 20) begin
      in_valid = (idx < 3);
      if (idx < 3) begin
        imm_src = bp_src[idx]; immediate = bp_imm[idx]; base_instr = bp_base[idx];
      end
      acc = in_valid && in_ready;
      if (out_valid && k < 3) begin
        check("bp_order", 64'(instruction), 64'(bp_exp[k]));
        k++;
      end
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_drain_count", 64'(k), 64'd3);
    check_cnt();

    // Async reset with both stages full
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      imm_src = bp_src[c]; immediate = bp_imm[c]; base_instr = bp_base[c];
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_instr", 64'(instruction), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check_cnt();
    xact("resume", 3'b000, 64'd5, 32'h0000_0013, 32'h0050_0013, 1'b0, 1'b0, 1'b0);

    // Saturation: narrow counter stops at 3
    for (int e = 0; e < 5; e++)
      xact("sat", 3'b000, 64'h0000_0000_0000_0800, 32'h0000_0013, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
    check("sat_final_w2", 64'(err_cnt2), 64'd3);
    check("sat_final_w16", 64'(err_cnt), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
